// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one RAM port between instruction fetch (IFU) and
//            load/store (LSU), one transaction at a time. Optional perf
//            counters are built when MEM_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,            // asynchronous, active-low

    input  logic                  ifu_req_valid,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,

    input  logic                  lsu_req_valid,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_req_ready,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_rdata,

`ifdef MEM_ARB_PERF_EN
    output logic [31:0]           perf_ifu_grants,
    output logic [31:0]           perf_lsu_grants,
    output logic [31:0]           perf_stall_cycles,
`endif

    output logic                  ram_req_valid,
    output logic                  ram_req_wen,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_wmask,
    input  logic                  ram_ready,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int   c_MASK_W  = DATA_W / 8;
    localparam logic c_OWN_IFU = 1'b0;
    localparam logic c_OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_owner;
    logic                  r_last_grant;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_ifu_data;
    logic [DATA_W-1:0]     r_lsu_rdata;

    logic                  w_pick_lsu;
    logic                  w_pick_ifu;
    logic                  w_ifu_hs;
    logic                  w_lsu_hs;

    // ------------------------------------------------------------------
    // Arbitration policy
    // ------------------------------------------------------------------
    generate
        if (RR_EN != 0) begin : g_round_robin
            // On a tie the requester that did not win last time goes next.
            assign w_pick_lsu = lsu_req_valid &
                                (~ifu_req_valid | (r_last_grant == c_OWN_IFU));
        end else begin : g_fixed_prio
            assign w_pick_lsu = lsu_req_valid;
        end
    endgenerate

    assign w_pick_ifu = ifu_req_valid & ~w_pick_lsu;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and request-side handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                ifu_req_ready = rst & w_pick_ifu;
                lsu_req_ready = rst & w_pick_lsu;
                if (w_pick_ifu || w_pick_lsu) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ram_ready) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_ifu_hs = ifu_req_ready;
    assign w_lsu_hs = lsu_req_ready;

    // ------------------------------------------------------------------
    // Request latch, grant history and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= c_OWN_IFU;
            r_last_grant <= c_OWN_LSU;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_ifu_data   <= '0;
            r_lsu_rdata  <= '0;
        end else begin
            if (w_lsu_hs) begin
                r_owner      <= c_OWN_LSU;
                r_last_grant <= c_OWN_LSU;
                r_addr       <= lsu_req_addr;
                r_wen        <= lsu_req_wen;
                r_wdata      <= lsu_req_wdata;
                r_wmask      <= lsu_req_wmask;
            end else if (w_ifu_hs) begin
                r_owner      <= c_OWN_IFU;
                r_last_grant <= c_OWN_IFU;
                r_addr       <= ifu_req_addr;
                r_wen        <= 1'b0;
                r_wdata      <= '0;
                r_wmask      <= '1;
            end

            if ((r_state == S_BUSY) && ram_ready) begin
                if (r_owner == c_OWN_LSU) begin
                    r_lsu_rdata <= r_wen ? '0 : ram_rdata;
                end else begin
                    r_ifu_data  <= ram_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_req_valid  = (r_state == S_BUSY);
    assign ram_req_wen    = r_wen;
    assign ram_addr       = r_addr;
    assign ram_wdata      = r_wdata;
    assign ram_wmask      = r_wmask;

    assign ifu_resp_valid = (r_state == S_RESP) && (r_owner == c_OWN_IFU);
    assign lsu_resp_valid = (r_state == S_RESP) && (r_owner == c_OWN_LSU);
    assign ifu_resp_data  = r_ifu_data;
    assign lsu_resp_rdata = r_lsu_rdata;

`ifdef MEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_ifu;
    logic [31:0] r_perf_lsu;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (ifu_req_valid & ~ifu_req_ready) |
                     (lsu_req_valid & ~lsu_req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_ifu   <= '0;
            r_perf_lsu   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_ifu_hs && (r_perf_ifu != '1)) begin
                r_perf_ifu <= r_perf_ifu + 32'd1;
            end
            if (w_lsu_hs && (r_perf_lsu != '1)) begin
                r_perf_lsu <= r_perf_lsu + 32'd1;
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_ifu_grants   = r_perf_ifu;
    assign perf_lsu_grants   = r_perf_lsu;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter: a round-robin instance with a
//            RAM model and response queue, plus a fixed-priority instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [31:0] c_RD_XOR = 32'h8000_0013;

    typedef struct packed {
        logic        owner;     // 1 = LSU
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } ramreq_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    resp_t   resp_q[$];
    ramreq_t ram_q[$];

    // ---------------- round-robin instance ----------------
    logic        a_rst;
    logic        a_ifu_req_valid, a_ifu_req_ready, a_ifu_resp_valid;
    logic [31:0] a_ifu_req_addr, a_ifu_resp_data;
    logic        a_lsu_req_valid, a_lsu_req_wen, a_lsu_req_ready, a_lsu_resp_valid;
    logic [31:0] a_lsu_req_addr, a_lsu_req_wdata, a_lsu_resp_rdata;
    logic [3:0]  a_lsu_req_wmask;
    logic        a_ram_req_valid, a_ram_req_wen, a_ram_ready;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic [3:0]  a_ram_wmask;

    // ---------------- fixed-priority instance ----------------
    logic        b_rst;
    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid;
    logic [31:0] b_ifu_req_addr, b_ifu_resp_data;
    logic        b_lsu_req_valid, b_lsu_req_wen, b_lsu_req_ready, b_lsu_resp_valid;
    logic [31:0] b_lsu_req_addr, b_lsu_req_wdata, b_lsu_resp_rdata;
    logic [3:0]  b_lsu_req_wmask;
    logic        b_ram_req_valid, b_ram_req_wen, b_ram_ready;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_ram_wmask;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] a_perf_ifu, a_perf_lsu, a_perf_stall;
    logic [31:0] b_perf_ifu, b_perf_lsu, b_perf_stall;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) u_dut_rr (
        .clk               (clk),
        .rst               (a_rst),
        .ifu_req_valid     (a_ifu_req_valid),
        .ifu_req_addr      (a_ifu_req_addr),
        .ifu_req_ready     (a_ifu_req_ready),
        .ifu_resp_valid    (a_ifu_resp_valid),
        .ifu_resp_data     (a_ifu_resp_data),
        .lsu_req_valid     (a_lsu_req_valid),
        .lsu_req_wen       (a_lsu_req_wen),
        .lsu_req_addr      (a_lsu_req_addr),
        .lsu_req_wdata     (a_lsu_req_wdata),
        .lsu_req_wmask     (a_lsu_req_wmask),
        .lsu_req_ready     (a_lsu_req_ready),
        .lsu_resp_valid    (a_lsu_resp_valid),
        .lsu_resp_rdata    (a_lsu_resp_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_ifu_grants   (a_perf_ifu),
        .perf_lsu_grants   (a_perf_lsu),
        .perf_stall_cycles (a_perf_stall),
`endif
        .ram_req_valid     (a_ram_req_valid),
        .ram_req_wen       (a_ram_req_wen),
        .ram_addr          (a_ram_addr),
        .ram_wdata         (a_ram_wdata),
        .ram_wmask         (a_ram_wmask),
        .ram_ready         (a_ram_ready),
        .ram_rdata         (a_ram_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) u_dut_fixed (
        .clk               (clk),
        .rst               (b_rst),
        .ifu_req_valid     (b_ifu_req_valid),
        .ifu_req_addr      (b_ifu_req_addr),
        .ifu_req_ready     (b_ifu_req_ready),
        .ifu_resp_valid    (b_ifu_resp_valid),
        .ifu_resp_data     (b_ifu_resp_data),
        .lsu_req_valid     (b_lsu_req_valid),
        .lsu_req_wen       (b_lsu_req_wen),
        .lsu_req_addr      (b_lsu_req_addr),
        .lsu_req_wdata     (b_lsu_req_wdata),
        .lsu_req_wmask     (b_lsu_req_wmask),
        .lsu_req_ready     (b_lsu_req_ready),
        .lsu_resp_valid    (b_lsu_resp_valid),
        .lsu_resp_rdata    (b_lsu_resp_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_ifu_grants   (b_perf_ifu),
        .perf_lsu_grants   (b_perf_lsu),
        .perf_stall_cycles (b_perf_stall),
`endif
        .ram_req_valid     (b_ram_req_valid),
        .ram_req_wen       (b_ram_req_wen),
        .ram_addr          (b_ram_addr),
        .ram_wdata         (b_ram_wdata),
        .ram_wmask         (b_ram_wmask),
        .ram_ready         (b_ram_ready),
        .ram_rdata         (b_ram_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_a_outputs_zero(input string name);
        chk(name, 64'(|{a_ifu_req_ready, a_ifu_resp_valid, a_ifu_resp_data,
                        a_lsu_req_ready, a_lsu_resp_valid, a_lsu_resp_rdata,
                        a_ram_req_valid, a_ram_req_wen, a_ram_addr,
                        a_ram_wdata, a_ram_wmask}), 64'd0);
    endtask

    // ---------------- RAM model + request-side checker (instance A) ----------------
    int      a_lat = 1;
    int      a_cnt = 0;
    ramreq_t a_cur;

    always @(negedge clk) begin : ram_model_a
        ramreq_t e;
        if (!a_rst || !a_ram_req_valid) begin
            a_cnt       = 0;
            a_ram_ready = 1'b0;
        end else begin
            if (a_cnt == 0) begin
                a_cur = '{wen: a_ram_req_wen, addr: a_ram_addr,
                          wdata: a_ram_wdata, wmask: a_ram_wmask};
                if (ram_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ram_unexpected_req: got addr 0x%0h expected no request", a_ram_addr);
                end else begin
                    e = ram_q.pop_front();
                    chk("ram_wen", 64'(a_cur.wen), 64'(e.wen));
                    chk("ram_addr", 64'(a_cur.addr), 64'(e.addr));
                    chk("ram_wmask", 64'(a_cur.wmask), 64'(e.wmask));
                    if (e.wen) chk("ram_wdata", 64'(a_cur.wdata), 64'(e.wdata));
                end
            end else begin
                chk("ram_hold_addr", 64'(a_ram_addr), 64'(a_cur.addr));
                chk("ram_hold_ctl", 64'({a_ram_req_wen, a_ram_wmask, a_ram_wdata}),
                                    64'({a_cur.wen, a_cur.wmask, a_cur.wdata}));
            end
            chk("busy_ready_low", 64'({a_ifu_req_ready, a_lsu_req_ready}), 64'd0);
            a_cnt++;
            if (a_cnt == a_lat) begin
                a_ram_ready = 1'b1;
                a_ram_rdata = a_cur.addr ^ c_RD_XOR;
            end else begin
                a_ram_ready = 1'b0;
            end
        end
    end

    // ---------------- response monitor (instance A) ----------------
    always @(posedge clk) begin : resp_mon_a
        resp_t r;
        #1;
        if (a_rst) begin
            chk("resp_onehot", 64'(a_ifu_resp_valid & a_lsu_resp_valid), 64'd0);
            chk("resp_latency", 64'(a_ifu_resp_valid | a_lsu_resp_valid), 64'(a_ram_ready));
            if (a_ifu_resp_valid || a_lsu_resp_valid) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: got ifu=%0b lsu=%0b expected none",
                             a_ifu_resp_valid, a_lsu_resp_valid);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_owner", 64'(a_lsu_resp_valid), 64'(r.owner));
                    chk("resp_data", 64'(a_lsu_resp_valid ? a_lsu_resp_rdata : a_ifu_resp_data),
                                     64'(r.data));
                end
            end
        end
    end

    // ---------------- requester drivers (instance A) ----------------
    task automatic ifu_req(input logic [31:0] addr);
        int n = 0;
        @(negedge clk);
        a_ifu_req_valid = 1'b1;
        a_ifu_req_addr  = addr;
        #1;
        while (!a_ifu_req_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!a_ifu_req_ready) begin
            checks++;
            failures++;
            $display("FAIL ifu_handshake_timeout: got no ready expected ready for 0x%0h", addr);
            a_ifu_req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            a_ifu_req_valid = 1'b0;
        end
    endtask

    task automatic lsu_req(input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask);
        int n = 0;
        @(negedge clk);
        a_lsu_req_valid = 1'b1;
        a_lsu_req_addr  = addr;
        a_lsu_req_wen   = wen;
        a_lsu_req_wdata = wdata;
        a_lsu_req_wmask = wmask;
        #1;
        while (!a_lsu_req_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!a_lsu_req_ready) begin
            checks++;
            failures++;
            $display("FAIL lsu_handshake_timeout: got no ready expected ready for 0x%0h", addr);
            a_lsu_req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            a_lsu_req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || a_ram_req_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (resp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", resp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- fixed-priority instance: RAM, monitor, stimulus ----------------
    int b_lsu_resps = 0;
    int b_ifu_rdy   = 0;
    int b_ifu_resps = 0;
    bit b_done      = 1'b0;

    always @(negedge clk) begin
        b_ram_ready = b_rst & b_ram_req_valid;
        b_ram_rdata = 32'hCAFE_F00D;
    end

    always @(posedge clk) begin
        #1;
        if (b_rst) begin
            if (b_ifu_req_ready)  b_ifu_rdy++;
            if (b_ifu_resp_valid) b_ifu_resps++;
            if (b_ram_req_valid)  chk("fixed_ram_addr", 64'(b_ram_addr), 64'h6000);
            if (b_lsu_resp_valid) begin
                b_lsu_resps++;
                chk("fixed_lsu_rdata", 64'(b_lsu_resp_rdata), 64'hCAFE_F00D);
            end
        end
    end

    initial begin : stim_fixed
        int n = 0;
        b_rst = 1'b0;
        b_ifu_req_valid = 1'b0; b_ifu_req_addr  = 32'h8000_0000;
        b_lsu_req_valid = 1'b0; b_lsu_req_wen   = 1'b0;
        b_lsu_req_addr  = 32'h6000; b_lsu_req_wdata = 32'h0; b_lsu_req_wmask = 4'hF;
        b_ram_ready = 1'b0; b_ram_rdata = 32'h0;
        repeat (2) @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_ifu_req_valid = 1'b1;
        b_lsu_req_valid = 1'b1;
        while (b_lsu_resps < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        b_ifu_req_valid = 1'b0;
        b_lsu_req_valid = 1'b0;
        b_done = 1'b1;
    end

    // ---------------- main stimulus (instance A) ----------------
    initial begin : stim_main
        int n = 0;
        a_rst = 1'b0;
        a_ifu_req_valid = 1'b1; a_ifu_req_addr = 32'h8000_0000;
        a_lsu_req_valid = 1'b0; a_lsu_req_wen  = 1'b0; a_lsu_req_addr = 32'h0;
        a_lsu_req_wdata = 32'h0; a_lsu_req_wmask = 4'h0;
        a_ram_ready = 1'b0; a_ram_rdata = 32'h0;

        // Reset holds every output low, even with a request pending.
        repeat (3) @(negedge clk);
        #1;
        chk_a_outputs_zero("reset_outputs_zero");
        a_ifu_req_valid = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;

        // IFU-only fetch, RAM answers after 3 cycles.
        a_lat = 3;
        ram_q.push_back('{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 4'hF});
        resp_q.push_back('{owner: 1'b0, data: 32'h0000_0013});
        ifu_req(32'h8000_0000);
        drain();

        // LSU partial write: response data must be 0.
        a_lat = 2;
        ram_q.push_back('{wen: 1'b1, addr: 32'h1000, wdata: 32'hDEAD_BEEF, wmask: 4'h3});
        resp_q.push_back('{owner: 1'b1, data: 32'h0});
        lsu_req(32'h1000, 1'b1, 32'hDEAD_BEEF, 4'h3);
        drain();

        // LSU read at minimum latency.
        a_lat = 1;
        ram_q.push_back('{wen: 1'b0, addr: 32'h2000, wdata: 32'h0, wmask: 4'hF});
        resp_q.push_back('{owner: 1'b1, data: 32'h8000_2013});
        lsu_req(32'h2000, 1'b0, 32'h5555_5555, 4'hF);
        drain();

        // Reset during BUSY: transaction dropped, no response.
        a_lat = 6;
        ram_q.push_back('{wen: 1'b0, addr: 32'h3000, wdata: 32'h0, wmask: 4'hF});
        ifu_req(32'h3000);
        @(negedge clk);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        @(negedge clk);
        #1;
        chk_a_outputs_zero("midreset_outputs_zero");
        repeat (2) @(negedge clk);
        a_rst = 1'b1;

        a_lat = 1;
        ram_q.push_back('{wen: 1'b0, addr: 32'h8000_0004, wdata: 32'h0, wmask: 4'hF});
        resp_q.push_back('{owner: 1'b0, data: 32'h0000_0017});
        ifu_req(32'h8000_0004);
        drain();

        // Round-robin from reset: 4 IFU and 2 LSU contending.
        @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        a_lat = 1;
        ram_q.push_back('{wen: 1'b0, addr: 32'h8000_0100, wdata: 32'h0, wmask: 4'hF});
        ram_q.push_back('{wen: 1'b0, addr: 32'h4000,      wdata: 32'h0, wmask: 4'hF});
        ram_q.push_back('{wen: 1'b0, addr: 32'h8000_0104, wdata: 32'h0, wmask: 4'hF});
        ram_q.push_back('{wen: 1'b1, addr: 32'h5000,      wdata: 32'h1234_5678, wmask: 4'hF});
        ram_q.push_back('{wen: 1'b0, addr: 32'h8000_0108, wdata: 32'h0, wmask: 4'hF});
        ram_q.push_back('{wen: 1'b0, addr: 32'h8000_010C, wdata: 32'h0, wmask: 4'hF});
        resp_q.push_back('{owner: 1'b0, data: 32'h0000_0113});
        resp_q.push_back('{owner: 1'b1, data: 32'h8000_4013});
        resp_q.push_back('{owner: 1'b0, data: 32'h0000_0117});
        resp_q.push_back('{owner: 1'b1, data: 32'h0});
        resp_q.push_back('{owner: 1'b0, data: 32'h0000_011B});
        resp_q.push_back('{owner: 1'b0, data: 32'h0000_011F});
        fork
            begin
                ifu_req(32'h8000_0100);
                ifu_req(32'h8000_0104);
                ifu_req(32'h8000_0108);
                ifu_req(32'h8000_010C);
            end
            begin
                lsu_req(32'h4000, 1'b0, 32'h0, 4'hF);
                lsu_req(32'h5000, 1'b1, 32'h1234_5678, 4'hF);
            end
        join
        drain();

`ifdef MEM_ARB_PERF_EN
        chk("perf_ifu_grants",   64'(a_perf_ifu),   64'd4);
        chk("perf_lsu_grants",   64'(a_perf_lsu),   64'd2);
        chk("perf_stall_cycles", 64'(a_perf_stall), 64'd14);
`endif

        while (!b_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("fixed_done", 64'(b_done), 64'd1);
        chk("fixed_lsu_resps", 64'(b_lsu_resps), 64'd4);
        chk("fixed_ifu_ready_never", 64'(b_ifu_rdy), 64'd0);
        chk("fixed_ifu_resp_never", 64'(b_ifu_resps), 64'd0);

        chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        chk("ram_queue_empty", 64'(ram_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
